// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data,
// with data priority bounded by a starvation counter and fetch-kill handling.
//
// state  | meaning
// IDLE   | no transaction outstanding; selects owner and drives the memory request
// BUSY_I | fetch accepted by memory, waiting for its response
// BUSY_D | data access accepted by memory, waiting for its response
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fetch_stall
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int BE_W  = DATA_W / 8;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             kill_pend_q, kill_pend_d;

  logic owner;
  logic sel_valid;
  logic starved;
  logic grant;

  // Fetch wins only once data has used up its quota while fetch was waiting.
  always_comb begin
    starved   = if_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    sel_valid = 1'b0;
    owner     = OWN_I;
    if (d_req && !starved) begin
      sel_valid = 1'b1;
      owner     = OWN_D;
    end else if (if_req) begin
      sel_valid = 1'b1;
      owner     = OWN_I;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    kill_pend_d  = kill_pend_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    grant        = 1'b0;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          mem_req = 1'b1;
          if (owner == OWN_D) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
          end else begin
            mem_addr = if_addr;
            mem_be   = {BE_W{1'b1}};
          end
        end
        grant = mem_req && mem_ready;
        if (grant) begin
          if (owner == OWN_D) begin
            d_gnt   = 1'b1;
            state_d = BUSY_D;
            if (if_req) begin
              if (starve_cnt_q != CNT_W'(STARVE_LIMIT))
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
              starve_cnt_d = '0;
            end
          end else begin
            if_gnt       = 1'b1;
            state_d      = BUSY_I;
            starve_cnt_d = '0;
          end
        end
      end
      BUSY_I: begin
        if (mem_rvalid) begin
          if_rvalid   = !(kill_pend_q || if_kill);
          if_rdata    = if_rvalid ? mem_rdata : '0;
          kill_pend_d = 1'b0;
          state_d     = IDLE;
        end else if (if_kill) begin
          kill_pend_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fetch_stall = if_req && !if_gnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      kill_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      kill_pend_q  <= kill_pend_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after the rising
// edge, outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_req, if_kill, d_req, d_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, fetch_stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; if_req = 0; if_kill = 0; d_req = 0; d_we = 0; mem_ready = 0;
    mem_rvalid = 0; if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d_be = '0;
    smp();
    chk1("rst mem_req", mem_req, 1'b0);
    chk1("rst if_gnt", if_gnt, 1'b0);
    chk1("rst d_gnt", d_gnt, 1'b0);
    chk1("rst fetch_stall", fetch_stall, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    cyc(); n_rst = 1'b1;
    cyc();

    // fetch only, response two cycles after grant
    if_req = 1; if_addr = 32'h1000_0000; mem_ready = 1;
    smp();
    chk1("t1 if_gnt", if_gnt, 1'b1);
    chk1("t1 mem_req", mem_req, 1'b1);
    chk1("t1 mem_we", mem_we, 1'b0);
    chk32("t1 mem_addr", mem_addr, 32'h1000_0000);
    chk32("t1 mem_be", {28'h0, mem_be}, 32'hF);
    chk32("t1 mem_wdata", mem_wdata, 32'h0);
    chk1("t1 fetch_stall", fetch_stall, 1'b0);
    chk1("t1 d_gnt", d_gnt, 1'b0);
    cyc(); if_req = 0;
    smp();
    chk1("t1 busy mem_req", mem_req, 1'b0);
    chk1("t1 early rvalid", if_rvalid, 1'b0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0033;
    smp();
    chk1("t1 if_rvalid", if_rvalid, 1'b1);
    chk32("t1 if_rdata", if_rdata, 32'h0000_0033);
    chk1("t1 d_rvalid", d_rvalid, 1'b0);
    chk32("t1 d_rdata", d_rdata, 32'h0);
    cyc(); mem_rvalid = 0;

    // simultaneous store and fetch: data first
    if_req = 1; if_addr = 32'h1000_0004;
    d_req = 1; d_we = 1; d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    smp();
    chk1("t2 d_gnt", d_gnt, 1'b1);
    chk1("t2 if_gnt", if_gnt, 1'b0);
    chk1("t2 mem_we", mem_we, 1'b1);
    chk32("t2 mem_addr", mem_addr, 32'h2000_0004);
    chk32("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk1("t2 fetch_stall", fetch_stall, 1'b1);
    cyc(); d_req = 0; d_we = 0;
    smp();
    chk1("t2 busy mem_req", mem_req, 1'b0);
    chk1("t2 busy stall", fetch_stall, 1'b1);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0;
    smp();
    chk1("t2 d_rvalid", d_rvalid, 1'b1);
    chk1("t2 no gnt in resp", if_gnt, 1'b0);
    chk1("t2 resp stall", fetch_stall, 1'b1);
    cyc(); mem_rvalid = 0;
    smp();
    chk1("t2 if_gnt", if_gnt, 1'b1);
    chk32("t2 if mem_addr", mem_addr, 32'h1000_0004);
    chk1("t2 stall released", fetch_stall, 1'b0);
    cyc(); if_req = 0;
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    smp();
    chk32("t2 if_rdata", if_rdata, 32'h0000_0013);
    cyc(); mem_rvalid = 0;

    // starvation: 4 loads, then fetch, then 4 loads again, then fetch
    if_req = 1; if_addr = 32'h1000_0100;
    d_req = 1; d_we = 0; d_addr = 32'h3000_0000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        smp();
        chk1("t3 d_gnt", d_gnt, 1'b1);
        chk1("t3 if_gnt", if_gnt, 1'b0);
        cyc(); mem_rvalid = 1; mem_rdata = 32'h100 + k;
        smp();
        chk1("t3 d_rvalid", d_rvalid, 1'b1);
        chk32("t3 d_rdata", d_rdata, 32'h100 + k);
        cyc(); mem_rvalid = 0;
      end
      smp();
      chk1("t3 starve if_gnt", if_gnt, 1'b1);
      chk1("t3 starve d_gnt", d_gnt, 1'b0);
      chk32("t3 starve addr", mem_addr, 32'h1000_0100);
      if (r == 1) begin
        cyc(); if_req = 0; d_req = 0;
      end else begin
        cyc();
      end
      mem_rvalid = 1; mem_rdata = 32'h0000_0200;
      smp();
      chk1("t3 if_rvalid", if_rvalid, 1'b1);
      cyc(); mem_rvalid = 0;
    end

    // kill during BUSY_I
    if_req = 1; if_addr = 32'h1000_0008;
    smp();
    chk1("t4 if_gnt", if_gnt, 1'b1);
    cyc(); if_req = 0; if_kill = 1;
    cyc(); if_kill = 0;
    cyc();
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_00AA;
    smp();
    chk1("t4 killed rvalid", if_rvalid, 1'b0);
    chk32("t4 killed rdata", if_rdata, 32'h0);
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h1000_000C;
    smp();
    chk1("t4 refetch gnt", if_gnt, 1'b1);
    cyc(); if_req = 0;
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0077;
    smp();
    chk1("t4 refetch rvalid", if_rvalid, 1'b1);
    chk32("t4 refetch rdata", if_rdata, 32'h0000_0077);
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h1000_0010;
    smp();
    chk1("t4b if_gnt", if_gnt, 1'b1);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0055; if_kill = 1;
    smp();
    chk1("t4b same-cycle kill", if_rvalid, 1'b0);
    cyc(); mem_rvalid = 0; if_kill = 0;

    // memory back-pressure
    mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h2000_0010;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk1("t5 wait d_gnt", d_gnt, 1'b0);
      chk1("t5 wait mem_req", mem_req, 1'b1);
      chk32("t5 wait addr", mem_addr, 32'h2000_0010);
      cyc();
    end
    mem_ready = 1;
    smp();
    chk1("t5 d_gnt", d_gnt, 1'b1);
    cyc(); d_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_1234; if_kill = 1;
    smp();
    chk1("t5 d_rvalid", d_rvalid, 1'b1);
    chk32("t5 d_rdata", d_rdata, 32'h0000_1234);
    chk1("t5 if_rvalid quiet", if_rvalid, 1'b0);
    cyc(); mem_rvalid = 0; if_kill = 0;

    // reset during BUSY_D, stray response afterwards
    d_req = 1; d_we = 1; d_addr = 32'h2000_0020; d_wdata = 32'h1111_2222;
    smp();
    chk1("t6 d_gnt", d_gnt, 1'b1);
    cyc(); d_req = 0; d_we = 0; n_rst = 0;
    smp();
    chk1("t6 rst mem_req", mem_req, 1'b0);
    chk1("t6 rst d_rvalid", d_rvalid, 1'b0);
    cyc(); n_rst = 1;
    cyc(); mem_rvalid = 1; mem_rdata = 32'h0000_0099;
    smp();
    chk1("t6 stray d_rvalid", d_rvalid, 1'b0);
    chk32("t6 stray d_rdata", d_rdata, 32'h0);
    chk1("t6 stray if_rvalid", if_rvalid, 1'b0);
    chk1("t6 stray mem_req", mem_req, 1'b0);
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h1000_0020;
    smp();
    chk1("t6 idle if_gnt", if_gnt, 1'b1);
    cyc(); if_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the 5-stage pipelined core.
- Data accesses have priority, with a starvation limit that guarantees fetch progress.
- Allows one outstanding transaction at a time and routes the response back to its owner.
- Drops a fetch response when fetch is redirected by a branch/jump flush while that fetch is in flight.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enable is DATA_W/8 bits.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while a fetch is pending; the next grant goes to fetch.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- if_req  input  1  fetch request, held until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_kill  input  1  flush/redirect; the in-flight fetch response is discarded
- if_gnt  output  1  fetch request accepted (1-cycle pulse)
- if_rvalid  output  1  fetch data valid (1-cycle pulse)
- if_rdata  output  DATA_W  fetch data
- d_req  input  1  data request, held until d_gnt
- d_we  input  1  1 = store
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_be  input  DATA_W/8  store byte enables
- d_gnt  output  1  data request accepted (1-cycle pulse)
- d_rvalid  output  1  load data / store acknowledge (1-cycle pulse)
- d_rdata  output  DATA_W  load data
- mem_req  output  1  memory request
- mem_we  output  1  memory write
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_be  output  DATA_W/8  memory byte enables
- mem_ready  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  response valid; one response per accepted request, latency ≥1 cycle
- mem_rdata  input  DATA_W  response data
- fetch_stall  output  1  if_req & ~if_gnt, for the pipeline enable

Behaviour:
- Reset (asynchronous, n_rst=0):
  - State=IDLE, starve_cnt=0, kill_pend=0.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction. A later stray mem_rvalid in IDLE is ignored.
- State IDLE:
  - Selects an owner: data if d_req and not (if_req and starve_cnt==STARVE_LIMIT); otherwise fetch if if_req.
  - mem_req/mem_we/mem_addr/mem_wdata/mem_be are driven combinationally from the selected owner.
  - Fetch drives mem_we=0, mem_be=all ones, mem_wdata=0.
  - With no request, mem_req=0 and the other memory outputs are 0.
- Grant:
  - Occurs when mem_req & mem_ready in IDLE: the owner's gnt pulses that cycle.
  - Next state is BUSY_I or BUSY_D.
  - If mem_ready=0, the selection is re-evaluated every cycle; a requester must hold its request.
- BUSY_I / BUSY_D:
  - mem_req=0.
  - On mem_rvalid: the owner's rvalid pulses with rdata = mem_rdata in the same cycle (combinational pass-through), and the state returns to IDLE.
  - No new grant in the response cycle, so back-to-back accesses have a minimum 1-cycle gap.
- Starvation counter:
  - Increments on each d_gnt while if_req=1, saturating at STARVE_LIMIT.
  - Clears on if_gnt, or when a data grant occurs with if_req=0.
- Kill:
  - if_kill in BUSY_I sets kill_pend. The matching response then produces if_rvalid=0, and kill_pend clears on that mem_rvalid.
  - if_kill in the same cycle as the fetch mem_rvalid also suppresses if_rvalid.
  - if_kill in IDLE or BUSY_D has no effect. An un-granted if_req is withdrawn by the requester, not by the arbiter.
- if_rdata/d_rdata are 0 when the matching rvalid is 0.
- Simultaneous if_req and d_req with starve_cnt<STARVE_LIMIT: data wins.
- fetch_stall is combinational.

Decomposition:
- Shared package: arb_state_e enum {IDLE, BUSY_I, BUSY_D} and owner encoding constants OWN_I/OWN_D.
- No sub-module needed. Single module with one FSM and the starvation counter.

Test Plan:
- if_req only, addr 0x1000_0000, mem_ready=1, response after 2 cycles with 0x0000_0033 → if_gnt at cycle 0, if_rvalid=1 with if_rdata=0x0000_0033 at cycle 2, d_* quiet.
- if_req and d_req (store 0xDEADBEEF to 0x2000_0004, be=4'b1111) together → d_gnt first with mem_we=1 and mem_addr=0x2000_0004; fetch granted the cycle after d_rvalid + 1; fetch_stall high until then.
- d_req held continuously with if_req held, STARVE_LIMIT=4 → exactly 4 d_gnt, then 1 if_gnt, then counter 0 and data resumes.
- Fetch granted, if_kill pulsed in BUSY_I, mem_rvalid 3 cycles later → if_rvalid stays 0, state IDLE; next fetch returns normally.
- mem_ready=0 for 5 cycles with d_req held → no gnt, mem_req stays 1 with stable address; grant on the first mem_ready=1 cycle.
- n_rst low during BUSY_D, then mem_rvalid arrives after release → all outputs 0, d_rvalid not asserted, state IDLE.
